// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : icache_pkg
// Brief   : Shared line geometry, refill state encoding and word-slice helper
// Revision: 1.0
// ============================================================================
package icache_pkg;

    localparam int LINE_BITS   = 256;
    localparam int LINE_WORDS  = 8;
    localparam int OFFSET_BITS = 5;
    localparam int WORD_BITS   = 32;

    typedef logic [1:0] refill_state_t;
    localparam refill_state_t S_IDLE  = 2'd0;
    localparam refill_state_t S_FETCH = 2'd1;
    localparam refill_state_t S_DONE  = 2'd2;

    // Word 0 (lowest address) sits in the top 32 bits of the line.
    function automatic logic [7:0] word_msb(input logic [2:0] idx);
        return 8'(LINE_BITS - 1) - {idx, 5'b00000};
    endfunction

endpackage : icache_pkg
`default_nettype wire

// File: rtl/icache_refill.sv
`default_nettype none
// ============================================================================
// Module  : icache_refill
// Brief   : Critical-word-first 8-word line refill engine for the I-cache
// Revision: 1.0
// ============================================================================
module icache_refill
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 miss_req,
    input  logic [ADDR_W-1:0]    miss_addr,
    input  logic                 flush,
    output logic                 busy,
    output logic                 mem_rd_req,
    output logic [ADDR_W-1:0]    mem_rd_addr,
    input  logic                 mem_rd_ack,
    input  logic [31:0]          mem_rd_data,
    output logic [LINE_BITS-1:0] block_read_fIC,
    output logic                 block_read_valid,
    output logic [ADDR_W-1:0]    block_addr
);

    localparam int c_IDX_W  = $clog2(LINE_WORDS);
    localparam int c_BASE_W = ADDR_W - OFFSET_BITS;

    refill_state_t          r_state;
    refill_state_t          w_state_nxt;
    logic [c_BASE_W-1:0]    r_base;
    logic [c_IDX_W-1:0]     r_widx;
    logic [3:0]             r_cnt;
    logic [LINE_BITS-1:0]   r_line;

    logic                   w_accept;
    logic                   w_ack;
    logic                   w_unused_ok;

    // A flush in the same cycle as a request or an ack wins over both.
    assign w_accept = (r_state == S_IDLE)  && miss_req   && !flush;
    assign w_ack    = (r_state == S_FETCH) && mem_rd_ack && !flush;

    assign w_unused_ok = &{1'b0, miss_addr[1:0]};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_ack && (r_cnt == 4'd7)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Placement is by word index, so the line is independent of fetch order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_base <= '0;
            r_widx <= '0;
            r_cnt  <= '0;
            r_line <= '0;
        end else if (w_accept) begin
            r_base <= miss_addr[ADDR_W-1:OFFSET_BITS];
            r_widx <= miss_addr[OFFSET_BITS-1:2];
            r_cnt  <= '0;
        end else if (w_ack) begin
            r_line[word_msb(r_widx) -: WORD_BITS] <= mem_rd_data;
            r_widx <= r_widx + 1'b1;
            r_cnt  <= r_cnt + 4'd1;
        end
    end

    assign busy             = (r_state != S_IDLE);
    assign mem_rd_req       = (r_state == S_FETCH);
    assign mem_rd_addr      = {r_base, r_widx, 2'b00};
    assign block_read_valid = (r_state == S_DONE) && !flush;
    assign block_read_fIC   = r_line;
    assign block_addr       = {r_base, {OFFSET_BITS{1'b0}}};

endmodule : icache_refill
`default_nettype wire

// File: tb/tb_icache_refill.sv
`default_nettype none
// ============================================================================
// Module  : tb_icache_refill
// Brief   : Directed self-checking bench for icache_refill with a line model
// Revision: 1.0
// ============================================================================
module tb_icache_refill;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         flush;
    logic         busy;
    logic         mem_rd_req;
    logic [31:0]  mem_rd_addr;
    logic         mem_rd_ack;
    logic [31:0]  mem_rd_data;
    logic [255:0] block_read_fIC;
    logic         block_read_valid;
    logic [31:0]  block_addr;

    logic [31:0]  salt;
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc   = 0;
    int           t0    = 0;
    bit           chk_en = 1'b0;

    // Observation log, compared against hand-computed literals
    logic [31:0]  ack_log[$];
    int           valid_cnt;
    int           valid_cyc;
    logic [255:0] last_line;

    // Reference model: request list in fetch order plus the finished line
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    int           m_pos  = 0;
    logic [31:0]  m_addrs[8];
    logic [255:0] m_line;
    logic [31:0]  m_block_addr = '0;

    icache_refill #(.LINE_WORDS(8), .ADDR_W(32)) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .miss_req         (miss_req),
        .miss_addr        (miss_addr),
        .flush            (flush),
        .busy             (busy),
        .mem_rd_req       (mem_rd_req),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_ack       (mem_rd_ack),
        .mem_rd_data      (mem_rd_data),
        .block_read_fIC   (block_read_fIC),
        .block_read_valid (block_read_valid),
        .block_addr       (block_addr)
    );

    always #5 CLK = ~CLK;

    assign mem_rd_data = mem_rd_addr ^ salt;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(posedge CLK) begin
        if (RESET) begin
            m_busy       <= 1'b0;
            m_done       <= 1'b0;
            m_pos        <= 0;
            m_block_addr <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (flush) begin
                m_busy <= 1'b0;
            end else if (mem_rd_ack) begin
                if (m_pos == 7) m_done <= 1'b1;
                m_pos <= m_pos + 1;
            end
        end else if (miss_req && !flush) begin
            m_busy       <= 1'b1;
            m_pos        <= 0;
            m_block_addr <= miss_addr & ~32'h1F;
            for (int i = 0; i < 8; i++) begin
                m_addrs[i] <= (miss_addr & ~32'h1F)
                              + ((((miss_addr >> 2) + 32'(i)) & 32'h7) << 2);
                m_line[255-32*i -: 32] <= ((miss_addr & ~32'h1F) + 32'(4*i)) ^ salt;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("rd_req", mem_rd_req, m_busy && !m_done);
            if (m_busy && !m_done) chk("rd_addr", mem_rd_addr, m_addrs[m_pos]);
            chk("valid", block_read_valid, m_done && !flush);
            if (m_done && !flush) chk("line", block_read_fIC, m_line);
            chk("block_addr", block_addr, m_block_addr);
        end
        if (mem_rd_req && mem_rd_ack && !flush) ack_log.push_back(mem_rd_addr);
        if (block_read_valid) begin
            valid_cnt++;
            valid_cyc = cyc - t0;
            last_line = block_read_fIC;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic accept(input logic [31:0] addr);
        miss_req  = 1'b1;
        miss_addr = addr;
        t0        = cyc;
        ack_log.delete();
        valid_cnt = 0;
        valid_cyc = -1;
        tick();
        miss_req  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_idle_timeout"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_seq[8];
        exp_seq = '{32'h1234, 32'h1238, 32'h123C, 32'h1220,
                    32'h1224, 32'h1228, 32'h122C, 32'h1230};
        RESET = 1'b1; miss_req = 1'b1; miss_addr = 32'h40;
        flush = 1'b0; mem_rd_ack = 1'b0; salt = '0;
        valid_cnt = 0; valid_cyc = -1; last_line = '0;

        // Reset with a request held: nothing may be accepted
        tick(); tick();
        RESET = 1'b0; miss_req = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_req", mem_rd_req, 1'b0);
        chk("rst_addr", mem_rd_addr, 32'h0);
        chk("rst_line", block_read_fIC, 256'h0);
        chk("rst_valid", block_read_valid, 1'b0);
        chk("rst_baddr", block_addr, 32'h0);
        chk_en = 1'b1;
        tick();
        chk("rst_no_accept", busy, 1'b0);

        // Critical word first, ack held high, data = address
        accept(32'h0000_1234);
        mem_rd_ack = 1'b1;
        repeat (8) tick();
        mem_rd_ack = 1'b0;
        tick();
        chk("cwf_nacks", ack_log.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < ack_log.size()) chk("cwf_addr_seq", ack_log[i], exp_seq[i]);
        chk("cwf_valid_cnt", valid_cnt, 1);
        chk("cwf_valid_cyc", valid_cyc, 9);
        chk("cwf_word0", last_line[255:224], 32'h0000_1220);
        chk("cwf_word7", last_line[31:0], 32'h0000_123C);
        chk("cwf_baddr", block_addr, 32'h0000_1220);
        chk("cwf_idle", busy, 1'b0);

        // Wait states: ack every third cycle
        salt = 32'hA5A5_0000;
        accept(32'h0000_0000);
        for (int k = 1; k <= 26; k++) begin
            mem_rd_ack = ((k % 3) == 0) && (k <= 24);
            tick();
        end
        mem_rd_ack = 1'b0;
        chk("ws_valid_cnt", valid_cnt, 1);
        chk("ws_valid_cyc", valid_cyc, 25);
        chk("ws_nacks", ack_log.size(), 8);
        if (ack_log.size() == 8) chk("ws_last_addr", ack_log[7], 32'h1C);
        chk("ws_word3", last_line[159:128], 32'hA5A5_000C);
        wait_idle("ws");

        // Flush after the fourth ack, then a fresh refill next cycle
        salt = 32'h1111_0000;
        accept(32'h0000_03A8);
        mem_rd_ack = 1'b1;
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; mem_rd_ack = 1'b0;
        chk("fl_busy", busy, 1'b0);
        chk("fl_req", mem_rd_req, 1'b0);
        chk("fl_no_valid", valid_cnt, 0);
        accept(32'h0000_2000);
        mem_rd_ack = 1'b1;
        repeat (8) tick();
        mem_rd_ack = 1'b0;
        tick();
        chk("fl_new_valid_cnt", valid_cnt, 1);
        chk("fl_new_valid_cyc", valid_cyc, 9);
        chk("fl_new_baddr", block_addr, 32'h0000_2000);
        chk("fl_new_word7", last_line[31:0], 32'h1111_201C);

        // Requests during FETCH and DONE are dropped
        salt = 32'h2222_0000;
        accept(32'h0000_0100);
        mem_rd_ack = 1'b1;
        tick(); tick();
        miss_req = 1'b1; miss_addr = 32'h0000_0500;
        tick();
        miss_req = 1'b0;
        repeat (5) tick();
        miss_req = 1'b1; miss_addr = 32'h0000_0600;
        tick();
        miss_req = 1'b0; mem_rd_ack = 1'b0;
        tick(); tick();
        chk("ign_valid_cnt", valid_cnt, 1);
        chk("ign_busy", busy, 1'b0);
        chk("ign_baddr", block_addr, 32'h0000_0100);
        // flush wins over a simultaneous request in IDLE
        flush = 1'b1; miss_req = 1'b1; miss_addr = 32'h0000_0700;
        tick();
        flush = 1'b0; miss_req = 1'b0;
        chk("fm_busy", busy, 1'b0);
        tick();
        chk("fm_baddr", block_addr, 32'h0000_0100);

        // Reset after the fifth ack, then a clean refill of line 0xE0
        salt = 32'h3333_0000;
        accept(32'h0000_0044);
        mem_rd_ack = 1'b1;
        repeat (5) tick();
        RESET = 1'b1; mem_rd_ack = 1'b0;
        tick();
        RESET = 1'b0;
        chk("mr_busy", busy, 1'b0);
        chk("mr_req", mem_rd_req, 1'b0);
        chk("mr_addr", mem_rd_addr, 32'h0);
        chk("mr_line", block_read_fIC, 256'h0);
        chk("mr_baddr", block_addr, 32'h0);
        chk("mr_no_valid", valid_cnt, 0);
        tick();
        accept(32'h0000_00E0);
        mem_rd_ack = 1'b1;
        repeat (8) tick();
        mem_rd_ack = 1'b0;
        tick();
        chk("mr_new_valid_cnt", valid_cnt, 1);
        chk("mr_new_baddr", block_addr, 32'h0000_00E0);
        chk("mr_new_word0", last_line[255:224], 32'h3333_00E0);
        chk("mr_new_word7", last_line[31:0], 32'h3333_00FC);
        wait_idle("mr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_icache_refill
`default_nettype wire

// File: doc/icache_refill.md
# icache_refill

Line-refill engine sitting directly upstream of the instruction cache's miss path. On a miss it fetches the eight 32-bit words of the missing 32-byte line from a word-wide memory read port, critical word first. It assembles them into the 256-bit line format the cache consumes, then presents the line with a one-cycle valid pulse on `block_read_fIC`/`block_read_valid`.

## Interface
- `LINE_WORDS`, 8: words per line (fixed at 8 in this revision)
- `ADDR_W`, 32: address width
- `CLK` in 1: single clock, all logic on rising edge
- `RESET` in 1: synchronous, active-high reset
- `miss_req` in 1: refill request, sampled only in IDLE
- `miss_addr` in 32: faulting instruction address (byte address)
- `flush` in 1: synchronous abort of any refill in progress
- `busy` out 1: high whenever state is not IDLE
- `mem_rd_req` out 1: memory read request, held until acked
- `mem_rd_addr` out 32: word-aligned read address
- `mem_rd_ack` in 1: memory has returned `mem_rd_data` this cycle
- `mem_rd_data` in 32: read data, valid only when `mem_rd_ack`=1
- `block_read_fIC` out 256: assembled line
- `block_read_valid` out 1: one-cycle pulse, line complete
- `block_addr` out 32: line base address (`miss_addr & ~32'h1F`), held from accept until next accept

## Operation
- States: IDLE, FETCH, DONE.
- IDLE: `miss_req`=1 latches `base = miss_addr[31:5]` and `widx = miss_addr[4:2]`, clears `cnt`, goes to FETCH.
- FETCH:
  - `mem_rd_req`=1 and `mem_rd_addr = {base, widx, 2'b00}`.
  - On `mem_rd_ack`, `mem_rd_data` is written to `block_read_fIC[255-32*widx -: 32]`: word 0 (lowest address) occupies bits 255:224 and word 7 occupies 31:0.
  - Then `widx` increments mod 8, wrapping 7→0, and `cnt` increments.
  - The ack that brings `cnt` to 8 moves to DONE.
- DONE: `block_read_valid`=1 for exactly this cycle, `mem_rd_req`=0, then IDLE.
- Placement depends only on word index, never on fetch order. The assembled line is identical for any starting offset.
- `miss_req` outside IDLE is ignored and not queued. This includes the DONE cycle.
- `flush`=1 in FETCH or DONE: next state IDLE, `mem_rd_req` low next cycle, no `block_read_valid`, and data acked in the flush cycle is discarded. `flush` in IDLE has no effect. In IDLE, `flush` takes priority over a simultaneous `miss_req`, so the request is not accepted.
- `RESET` dominates `flush` and `miss_req`.
- `block_read_fIC` is not cleared between refills. Its contents are meaningful only in the `block_read_valid` cycle.

## Timing
- Reset values:
  - state IDLE
  - `busy`=0, `mem_rd_req`=0, `mem_rd_addr`=0
  - `block_read_fIC`=0, `block_read_valid`=0, `block_addr`=0
- Accept at cycle 0 (`miss_req` high in IDLE). `busy` and `mem_rd_req` go high at cycle 1.
- With `mem_rd_ack` held high, one word per cycle: acks at cycles 1–8, `block_read_valid` at cycle 9, IDLE at cycle 10. Minimum latency is 9 cycles.
- With wait states, `block_read_valid` comes one cycle after the 8th ack.
- `mem_rd_addr` changes only in the cycle after an ack.
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- Earliest next accept is the first IDLE cycle after DONE.
- Memory protocol: at most one outstanding read. An ack while `mem_rd_req`=0 is ignored.

## Structure
- Shared package `icache_pkg`:
  - `LINE_BITS`=256, `LINE_WORDS`=8, `OFFSET_BITS`=5
  - the refill state enum (IDLE/FETCH/DONE)
  - the word-slice helper constant (255-32*i) used by both cache and refill
- No sub-module. Flat single module: FSM, 3-bit wrap index, 4-bit count, 256-bit assembly register.

## Test plan
- Reset: assert `RESET` 2 cycles → all outputs 0 and `busy`=0. `miss_req` during reset is ignored.
- Critical-word-first:
  - Stimulus: `miss_addr`=0x0000_1234, ack held high, memory returns data = address.
  - Required: `mem_rd_addr` sequence 0x1234, 0x1238, 0x123C, 0x1220, 0x1224, 0x1228, 0x122C, 0x1230.
  - Required: valid at cycle 9, bits[255:224]=0x0000_1220, bits[31:0]=0x0000_123C, `block_addr`=0x1220.
- Wait states: `miss_addr`=0x0000_0000, ack every 3rd cycle (cycles 3,6,…,24) → valid at cycle 25 only, and `mem_rd_addr` stable between acks.
- Flush mid-refill: `flush` after 4th ack → `mem_rd_req`=0 and `busy`=0 next cycle, with no valid. A new `miss_req` to 0x0000_2000 the following cycle completes normally.
- Ignored requests: `miss_req` pulsed during FETCH and in the DONE cycle → no second refill and exactly one valid pulse. Simultaneous `flush`+`miss_req` in IDLE → nothing accepted.
- Reset mid-refill: `RESET` after 5th ack → outputs return to reset values next cycle with no valid. A later refill to 0x0000_00E0 yields the correct line.
